// File: rtl/request_assembler_pkg.sv
// Shared constants for the two-byte request framer: command codes, error codes, FSM states.
// Latency: n/a (declarations and pure helper functions only).
// Backpressure: n/a.
package request_assembler_pkg;

   // Highest command code the sensor decoder understands.
   localparam logic [7:0] CMD_MAX        = 8'h07;

   localparam logic [7:0] CMD_NOP        = 8'h00;
   localparam logic [7:0] CMD_READ       = 8'h01;
   localparam logic [7:0] CMD_READ_BURST = 8'h02;
   localparam logic [7:0] CMD_RESET_DEV  = 8'h03;
   localparam logic [7:0] CMD_CALIBRATE  = 8'h04;
   localparam logic [7:0] CMD_SLEEP      = 8'h05;
   localparam logic [7:0] CMD_WAKE       = 8'h06;
   localparam logic [7:0] CMD_STATUS     = 8'h07;

   localparam logic [7:0] ERR_TIMEOUT    = 8'hE0;
   localparam logic [7:0] ERR_BAD_CMD    = 8'hE1;
   localparam logic [7:0] ERR_BAD_ADDR   = 8'hE2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_ADDR,
      ST_CHECK,
      ST_HOLD,
      ST_ERROR
   } state_t;

   function automatic logic cmd_is_valid(input logic [7:0] cmd);
      return cmd <= CMD_MAX;
   endfunction

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] val);
      return (val == 8'hFF) ? val : val + 8'd1;
   endfunction

endpackage

// File: rtl/request_assembler_if.sv
// Byte-in / request-out bundle between UART_RX, the framer and the sensor decoder.
// Latency: n/a (wires only).
// Backpressure: request_valid/request_ready handshake; has_data is a strobe with no ready.
//   slave  : framer side  (consumes has_data/data_received/request_ready)
//   master : driver side  (produces has_data/data_received/request_ready)
interface request_assembler_if #(
   parameter int NUM_DEVICES = 32
);
   logic                   has_data;
   logic [7:0]             data_received;
   logic                   request_ready;
   logic                   request_valid;
   logic [7:0]             request;
   logic [NUM_DEVICES-1:0] device_selector;
   logic                   error_valid;
   logic [7:0]             error_code;
   logic [7:0]             overrun_count;

   modport slave (
      input  has_data, data_received, request_ready,
      output request_valid, request, device_selector,
      output error_valid, error_code, overrun_count
   );

   modport master (
      output has_data, data_received, request_ready,
      input  request_valid, request, device_selector,
      input  error_valid, error_code, overrun_count
   );
endinterface

// File: rtl/request_assembler_timer.sv
// Inter-byte timer: counts enabled clocks since the last clear, flags the final allowed cycle.
// Latency: expired is a decode of the registered count (same cycle as the count value).
// Backpressure: none; clear has priority over enable.
//   clock/reset : system clock, synchronous active-high reset
//   clear       : force count to zero
//   enable      : advance count by one this clock
//   expired     : count has reached TIMEOUT_CYCLES-1
module inter_byte_timer #(
   parameter int TIMEOUT_CYCLES = 2_500_000
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && (count_q != LAST)) begin
         // Holding at LAST keeps the counter from wrapping if the owner lingers.
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = (count_q == LAST);

endmodule

// File: rtl/request_assembler.sv
// Frames a command byte + address byte from UART_RX into {request, one-hot device_selector}.
// Latency: address strobe in N -> request_valid (or error_valid) in N+2; timeout error in N+1+TIMEOUT_CYCLES.
// Backpressure: request held until request_ready; bytes arriving while busy are dropped and counted.
//   clock/reset : system clock, synchronous active-high reset
//   bus         : slave side of request_assembler_if (byte strobe in, request/error/overrun out)
module request_assembler
   import request_assembler_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 2_500_000,
   parameter int NUM_DEVICES    = 32
) (
   input  logic                clock,
   input  logic                reset,
   request_assembler_if.slave  bus
);

   state_t                 state_q, state_d;
   logic [7:0]             cmd_q, cmd_d;
   logic [7:0]             addr_q, addr_d;
   logic [7:0]             request_q, request_d;
   logic [NUM_DEVICES-1:0] device_selector_q, device_selector_d;
   logic                   request_valid_q, request_valid_d;
   logic                   error_valid_q, error_valid_d;
   logic [7:0]             error_code_q, error_code_d;
   logic [7:0]             overrun_q, overrun_d;

   logic timer_clear, timer_enable, timer_expired;
   logic addr_ok;
   logic [NUM_DEVICES-1:0] sel_dec;

   // Timer runs only while waiting for the address and is zero on every entry.
   assign timer_enable = (state_q == ST_WAIT_ADDR);
   assign timer_clear  = (state_q != ST_WAIT_ADDR);

   inter_byte_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clock   (clock),
      .reset   (reset),
      .clear   (timer_clear),
      .enable  (timer_enable),
      .expired (timer_expired)
   );

   assign addr_ok = (int'(addr_q) < NUM_DEVICES);
   assign sel_dec = NUM_DEVICES'(1) << addr_q;

   always_comb begin
      state_d           = state_q;
      cmd_d             = cmd_q;
      addr_d            = addr_q;
      request_d         = request_q;
      device_selector_d = device_selector_q;
      request_valid_d   = request_valid_q;
      error_valid_d     = 1'b0;
      error_code_d      = error_code_q;
      overrun_d         = overrun_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.has_data) begin
               cmd_d   = bus.data_received;
               state_d = ST_WAIT_ADDR;
            end
         end
         ST_WAIT_ADDR: begin
            // A byte arriving on the expiry cycle still completes the frame.
            if (bus.has_data) begin
               addr_d  = bus.data_received;
               state_d = ST_CHECK;
            end else if (timer_expired) begin
               error_code_d  = ERR_TIMEOUT;
               error_valid_d = 1'b1;
               state_d       = ST_ERROR;
            end
         end
         ST_CHECK: begin
            // Bad command is reported in preference to bad address.
            if (!cmd_is_valid(cmd_q)) begin
               error_code_d  = ERR_BAD_CMD;
               error_valid_d = 1'b1;
               state_d       = ST_ERROR;
            end else if (!addr_ok) begin
               error_code_d  = ERR_BAD_ADDR;
               error_valid_d = 1'b1;
               state_d       = ST_ERROR;
            end else begin
               request_d         = cmd_q;
               device_selector_d = sel_dec;
               request_valid_d   = 1'b1;
               state_d           = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (bus.request_ready) begin
               request_valid_d   = 1'b0;
               device_selector_d = '0;
               state_d           = ST_IDLE;
            end
         end
         ST_ERROR: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Only IDLE and WAIT_ADDR consume bytes; anything else is an overrun.
      if (bus.has_data &&
          ((state_q == ST_CHECK) || (state_q == ST_HOLD) || (state_q == ST_ERROR))) begin
         overrun_d = sat_inc8(overrun_q);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q           <= ST_IDLE;
         cmd_q             <= '0;
         addr_q            <= '0;
         request_q         <= '0;
         device_selector_q <= '0;
         request_valid_q   <= 1'b0;
         error_valid_q     <= 1'b0;
         error_code_q      <= '0;
         overrun_q         <= '0;
      end else begin
         state_q           <= state_d;
         cmd_q             <= cmd_d;
         addr_q            <= addr_d;
         request_q         <= request_d;
         device_selector_q <= device_selector_d;
         request_valid_q   <= request_valid_d;
         error_valid_q     <= error_valid_d;
         error_code_q      <= error_code_d;
         overrun_q         <= overrun_d;
      end
   end

   assign bus.request_valid   = request_valid_q;
   assign bus.request         = request_q;
   assign bus.device_selector = device_selector_q;
   assign bus.error_valid     = error_valid_q;
   assign bus.error_code      = error_code_q;
   assign bus.overrun_count   = overrun_q;

endmodule

// File: tb/tb_request_assembler.sv
// Self-checking bench for request_assembler with a short timeout (100 cycles).
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_request_assembler;

   localparam int TO   = 100;
   localparam int NDEV = 32;

   logic clock;
   logic reset;

   request_assembler_if #(.NUM_DEVICES(NDEV)) bus ();

   request_assembler #(
      .TIMEOUT_CYCLES (TO),
      .NUM_DEVICES    (NDEV)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int         total = 0;
   int         bad   = 0;
   int         ovr_exp = 0;
   logic [7:0] last_code = 8'h00;

   typedef struct {
      logic [7:0]  cmd;
      logic [7:0]  addr;
      logic        exp_err;
      logic [7:0]  exp_code;
      logic [31:0] exp_sel;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.has_data      = 1'b1;
      bus.data_received = b;
      tick();
      bus.has_data      = 1'b0;
   endtask

   task automatic drop_byte();
      send_byte(8'h5A);
      if (ovr_exp < 255) ovr_exp++;
   endtask

   // Reference rules: bad command beats bad address; otherwise select bit 'addr'.
   task automatic model(input logic [7:0] cmd, input logic [7:0] addr,
                        output logic err, output logic [7:0] code, output logic [31:0] sel);
      err  = 1'b0;
      code = 8'h00;
      sel  = 32'h0;
      if (int'(cmd) > 7) begin
         err  = 1'b1;
         code = 8'hE1;
      end else if (int'(addr) >= NDEV) begin
         err  = 1'b1;
         code = 8'hE2;
      end else begin
         sel = 32'h1 << addr;
      end
   endtask

   // Full frame: command, address, then outcome at address-strobe + 2, then release.
   task automatic run_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic exp_err,
                            input logic [7:0] exp_code, input logic [31:0] exp_sel,
                            input bit inject, input string tag);
      send_byte(cmd);
      send_byte(addr);
      check({tag, ".check_vld"}, 32'(bus.request_valid), 32'h0);
      check({tag, ".check_err"}, 32'(bus.error_valid), 32'h0);
      if (inject) drop_byte(); else tick();
      if (exp_err) begin
         check({tag, ".err_vld"}, 32'(bus.error_valid), 32'h1);
         check({tag, ".err_code"}, 32'(bus.error_code), 32'(exp_code));
         check({tag, ".err_no_req"}, 32'(bus.request_valid), 32'h0);
         last_code = exp_code;
         if (inject) drop_byte(); else tick();
         check({tag, ".err_pulse"}, 32'(bus.error_valid), 32'h0);
         check({tag, ".err_held"}, 32'(bus.error_code), 32'(exp_code));
         check({tag, ".err_no_req2"}, 32'(bus.request_valid), 32'h0);
      end else begin
         check({tag, ".req_vld"}, 32'(bus.request_valid), 32'h1);
         check({tag, ".req"}, 32'(bus.request), 32'(cmd));
         check({tag, ".sel"}, bus.device_selector, exp_sel);
         check({tag, ".code_held"}, 32'(bus.error_code), 32'(last_code));
         if (inject) begin
            drop_byte();
            check({tag, ".hold_vld"}, 32'(bus.request_valid), 32'h1);
            check({tag, ".hold_sel"}, bus.device_selector, exp_sel);
         end
         bus.request_ready = 1'b1;
         tick();
         bus.request_ready = 1'b0;
         check({tag, ".rel_vld"}, 32'(bus.request_valid), 32'h0);
         check({tag, ".rel_sel"}, bus.device_selector, 32'h0);
      end
      check({tag, ".ovr"}, 32'(bus.overrun_count), 32'(ovr_exp));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".vld"}, 32'(bus.request_valid), 32'h0);
      check({tag, ".req"}, 32'(bus.request), 32'h0);
      check({tag, ".sel"}, bus.device_selector, 32'h0);
      check({tag, ".err"}, 32'(bus.error_valid), 32'h0);
      check({tag, ".code"}, 32'(bus.error_code), 32'h0);
      check({tag, ".ovr"}, 32'(bus.overrun_count), 32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        m_err;
      logic [7:0]  m_code;
      logic [31:0] m_sel;
      logic [7:0]  rc, ra;
      int          k;
      bit          saw_err;

      vecs[0] = '{8'h09, 8'h00, 1'b1, 8'hE1, 32'h0};
      vecs[1] = '{8'h01, 8'h20, 1'b1, 8'hE2, 32'h0};
      vecs[2] = '{8'h02, 8'h1F, 1'b0, 8'hE2, 32'h8000_0000};
      vecs[3] = '{8'h0A, 8'h40, 1'b1, 8'hE1, 32'h0};
      vecs[4] = '{8'h07, 8'h00, 1'b0, 8'hE1, 32'h0000_0001};
      vecs[5] = '{8'h08, 8'h03, 1'b1, 8'hE1, 32'h0};
      vecs[6] = '{8'h00, 8'h10, 1'b0, 8'hE1, 32'h0001_0000};
      vecs[7] = '{8'hFF, 8'hFF, 1'b1, 8'hE1, 32'h0};

      reset             = 1'b1;
      bus.has_data      = 1'b0;
      bus.data_received = 8'h00;
      bus.request_ready = 1'b0;
      repeat (3) tick();
      check_all_zero("reset");
      reset = 1'b0;
      tick();

      // Valid frame held without ready, then released.
      send_byte(8'h01);
      send_byte(8'h05);
      check("t1.check_vld", 32'(bus.request_valid), 32'h0);
      tick();
      check("t1.vld", 32'(bus.request_valid), 32'h1);
      check("t1.req", 32'(bus.request), 32'h01);
      check("t1.sel", bus.device_selector, 32'h0000_0020);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t1.hold_vld", 32'(bus.request_valid), 32'h1);
         check("t1.hold_sel", bus.device_selector, 32'h0000_0020);
      end
      bus.request_ready = 1'b1;
      tick();
      bus.request_ready = 1'b0;
      check("t1.rel_vld", 32'(bus.request_valid), 32'h0);
      check("t1.rel_sel", bus.device_selector, 32'h0);

      for (int i = 0; i < 8; i++) begin
         run_frame(vecs[i].cmd, vecs[i].addr, vecs[i].exp_err, vecs[i].exp_code,
                   vecs[i].exp_sel, 1'b0, $sformatf("vec%0d", i));
      end

      // Timeout: error pulse exactly TO+1 cycles after the command strobe.
      send_byte(8'h01);
      k = 1;
      while (!bus.error_valid && k < 3 * TO) begin
         tick();
         k++;
      end
      check("t4.timeout_cycle", 32'(k), 32'(TO + 1));
      check("t4.timeout_code", 32'(bus.error_code), 32'hE0);
      check("t4.timeout_no_req", 32'(bus.request_valid), 32'h0);
      last_code = 8'hE0;
      tick();
      check("t4.timeout_pulse", 32'(bus.error_valid), 32'h0);

      // Address arriving on the last allowed cycle wins over the timeout.
      send_byte(8'h01);
      saw_err = 1'b0;
      for (int i = 0; i < TO - 1; i++) begin
         tick();
         if (bus.error_valid) saw_err = 1'b1;
      end
      send_byte(8'h06);
      if (bus.error_valid) saw_err = 1'b1;
      tick();
      if (bus.error_valid) saw_err = 1'b1;
      check("t4.late_no_err", 32'(saw_err), 32'h0);
      check("t4.late_vld", 32'(bus.request_valid), 32'h1);
      check("t4.late_sel", bus.device_selector, 32'h0000_0040);
      bus.request_ready = 1'b1;
      tick();
      bus.request_ready = 1'b0;
      check("t4.late_rel", 32'(bus.request_valid), 32'h0);

      // request_ready high before the request exists has no effect.
      bus.request_ready = 1'b1;
      send_byte(8'h05);
      send_byte(8'h02);
      tick();
      check("rdy_early.vld", 32'(bus.request_valid), 32'h1);
      check("rdy_early.sel", bus.device_selector, 32'h0000_0004);
      tick();
      check("rdy_early.rel", 32'(bus.request_valid), 32'h0);
      bus.request_ready = 1'b0;

      // Overrun counting while a request is held, then saturation.
      send_byte(8'h04);
      send_byte(8'h03);
      tick();
      repeat (3) drop_byte();
      check("t5.ovr3", 32'(bus.overrun_count), 32'h3);
      check("t5.req", 32'(bus.request), 32'h04);
      check("t5.sel", bus.device_selector, 32'h0000_0008);
      check("t5.vld", 32'(bus.request_valid), 32'h1);
      repeat (297) drop_byte();
      check("t5.ovr_sat", 32'(bus.overrun_count), 32'hFF);
      check("t5.sel2", bus.device_selector, 32'h0000_0008);
      bus.request_ready = 1'b1;
      tick();
      bus.request_ready = 1'b0;
      check("t5.rel", 32'(bus.request_valid), 32'h0);

      // Reset in the middle of a frame.
      send_byte(8'h02);
      reset = 1'b1;
      tick();
      check_all_zero("t6.reset");
      reset     = 1'b0;
      ovr_exp   = 0;
      last_code = 8'h00;
      run_frame(8'h03, 8'h00, 1'b0, 8'h00, 32'h1, 1'b0, "t6.frame");

      // Random frames against the reference rules, with dropped bytes injected.
      for (int n = 0; n < 120; n++) begin
         rc = 8'($urandom_range(0, 12));
         ra = 8'($urandom_range(0, 40));
         model(rc, ra, m_err, m_code, m_sel);
         run_frame(rc, ra, m_err, m_code, m_sel, 1'($urandom_range(0, 1)),
                   $sformatf("rnd%0d", n));
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
